// File: rtl/relu_stream_seq.sv
// relu_stream_seq: valid/ready sequencer streaming a Q8.8 vector through a registered ReLU stage
module relu_stream_seq #(
    parameter int W     = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_bypass,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] neg_cnt,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [W-1:0]     in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [W-1:0]     out_data,
    output logic             out_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d, neg_q, neg_d;
    logic [W-1:0]     data_q, data_d;
    logic             byp_q, byp_d, val_q, val_d, last_q, last_d, done_q, done_d;
    logic             acc, drain, fin;
    assign in_rdy   = (state_q == RUN) && (!val_q || out_rdy);
    assign acc      = in_val && in_rdy;
    assign drain    = val_q && out_rdy;
    assign fin      = rem_q == LEN_W'(1);
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign neg_cnt  = neg_q;
    assign out_val  = val_q;
    assign out_data = data_q;
    assign out_last = last_q;
    // next state: job setup in IDLE, accept/replace the output register in RUN, wait for the last handshake in DRAIN
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        byp_d   = byp_q;
        val_d   = val_q;
        last_d  = last_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                neg_d = '0;
                if (cfg_len != '0) begin
                    state_d = RUN;
                    rem_d   = cfg_len;
                    byp_d   = cfg_bypass;
                end else begin
                    done_d = 1'b1;
                end
            end
            RUN: if (acc) begin
                data_d  = (byp_q || !in_data[W-1]) ? in_data : '0;
                val_d   = 1'b1;
                last_d  = fin;
                rem_d   = rem_q - LEN_W'(1);
                neg_d   = (!byp_q && in_data[W-1]) ? neg_q + LEN_W'(1) : neg_q;
                state_d = fin ? DRAIN : RUN;
            end else if (drain) begin
                val_d = 1'b0;
            end
            DRAIN: if (drain) begin
                val_d   = 1'b0;
                last_d  = 1'b0;
                state_d = last_q ? IDLE : DRAIN;
                done_d  = last_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset discards any pending output and suppresses done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            neg_q   <= '0;
            byp_q   <= 1'b0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            byp_q   <= byp_d;
            val_q   <= val_d;
            last_q  <= last_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_relu_stream_seq.sv
// tb_relu_stream_seq: directed and randomized checks of relu_stream_seq against a vector-level model
module tb_relu_stream_seq;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, cfg_bypass = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        busy, done, in_val = 1'b0, in_rdy, out_val, out_rdy = 1'b0, out_last;
    logic [7:0]  neg_cnt;
    logic [15:0] in_data = '0, out_data;
    logic [15:0] din [256];
    int          vecs = 0, errs = 0;

    relu_stream_seq #(.W(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_bypass(cfg_bypass),
        .busy(busy), .done(done), .neg_cnt(neg_cnt),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input logic [15:0] d, input bit byp);
        return (byp || $signed(d) >= 0) ? d : 16'h0000;
    endfunction

    // rmode: 0 = out_rdy always 1, 1 = pattern 1,0,0 repeating, 2 = random
    task automatic run_job(input int len, input bit byp, input int rmode, input bit poke);
        int ni = 0, no = 0, cyc = 0, negs = 0;
        bit stalled = 0;
        logic [15:0] held = '0;
        for (int i = 0; i < len; i++) if (!byp && din[i][15]) negs++;
        @(negedge clk);
        start = 1'b1; cfg_len = 8'(len); cfg_bypass = byp;
        @(negedge clk);
        start = 1'b0; cfg_len = 8'($urandom); cfg_bypass = ~byp;
        chk("busy_rise", busy, 1);
        while (no < len && cyc < 8 * len + 50) begin
            if (poke && cyc == 1) begin start = 1'b1; cfg_len = 8'd200; end
            else start = 1'b0;
            out_rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            in_val  = ni < len;
            in_data = din[ni];
            #1;
            if (out_val && !out_rdy) chk("bp_in_rdy", in_rdy, 0);
            if (stalled) chk("stall_data", {out_val, out_last, out_data}, {1'b1, 1'b0 | out_last, held});
            stalled = out_val && !out_rdy;
            held = out_data;
            if (out_val && out_rdy) begin
                chk("out_data", out_data, ref_out(din[no], byp));
                chk("out_last", out_last, no == len - 1);
                no++;
            end
            if (in_val && in_rdy) ni++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_val = 1'b0;
        chk("job_outputs", no, len);
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("out_val_idle", out_val, 0);
        chk("neg_cnt", neg_cnt, negs);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("neg_cnt_hold", neg_cnt, negs);
    endtask

    initial begin
        int ni, total;
        #1;
        chk("rst_outs", {busy, done, neg_cnt, in_rdy, out_val, out_data, out_last}, 0);
        @(negedge clk); rst = 1'b1;
        // basic ReLU
        din[0] = 16'h0100; din[1] = 16'hff00;
        run_job(2, 0, 0, 0);
        // zero-length job clears neg_cnt and pulses done without becoming busy
        @(negedge clk);
        start = 1'b1; cfg_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zl_busy", busy, 0);
        chk("zl_done", done, 1);
        chk("zl_out_val", out_val, 0);
        chk("zl_neg_cnt", neg_cnt, 0);
        @(negedge clk);
        chk("zl_done_clear", done, 0);
        // bypass
        din[0] = 16'h8000; din[1] = 16'h7fff; din[2] = 16'hff00;
        run_job(3, 1, 0, 0);
        // backpressure plus an ignored mid-job start
        din[0] = 16'h8000; din[1] = 16'h0000; din[2] = 16'h1234; din[3] = 16'hfffe;
        run_job(4, 0, 1, 1);
        // reset asserted after two accepts
        din[0] = 16'hff00; din[1] = 16'h0200;
        @(negedge clk);
        start = 1'b1; cfg_len = 8'd5; cfg_bypass = 1'b0;
        @(negedge clk);
        start = 1'b0; ni = 0;
        for (int c = 0; c < 20 && ni < 2; c++) begin
            in_val = 1'b1; in_data = din[ni]; out_rdy = 1'b1;
            #1;
            if (in_rdy) ni++;
            @(negedge clk);
        end
        chk("pre_rst_accepts", ni, 2);
        chk("pre_rst_state", {busy, out_val, out_data, neg_cnt}, {1'b1, 1'b1, 16'h0200, 8'd1});
        in_val = 1'b0; rst = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, done, neg_cnt, in_rdy, out_val, out_data, out_last}, 0);
        @(negedge clk);
        chk("mid_rst_hold", {busy, done, neg_cnt, in_rdy, out_val, out_data, out_last}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_no_done", {busy, done}, 0);
        din[0] = 16'hc000;
        run_job(1, 0, 0, 0);
        // random jobs
        total = 0;
        while (total < 10000) begin
            int len = $urandom_range(1, 255);
            for (int i = 0; i < len; i++) din[i] = 16'($urandom);
            run_job(len, $urandom_range(0, 3) == 0, 2, 0);
            total += len;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
